// File: rtl/step_pulse_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// step_pulse_scheduler_pkg
// Shared constants for the step pulse scheduler: default counter widths and
// the scheduler state encoding. Imported by the top and the phase counter.
// -----------------------------------------------------------------------------
package step_pulse_scheduler_pkg;

    // Default width of the step-period counter, in clock cycles
    localparam int DEF_CNT_W   = 28;

    // Default width of the step-count field
    localparam int DEF_STEPS_W = 16;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/step_phase_counter.sv
// -----------------------------------------------------------------------------
// step_phase_counter
// Free-running phase counter for one step period. Counts 0..i_period-1 and
// wraps while enabled; i_load forces it back to phase 0.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   i_load      restart at phase 0 (start of a move)
//   i_enable    advance the phase this cycle
//   i_period    effective step period in cycles (always > PULSE_W)
//   o_terminal  phase is the last one of the period
//   o_inWindow  phase lies inside the step-high window
//   o_fallNext  phase is the last high phase; step falls after this cycle
// -----------------------------------------------------------------------------
module step_phase_counter
    import step_pulse_scheduler_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] PULSE_W = CNT_W'(50)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_terminal,
    output logic             o_inWindow,
    output logic             o_fallNext
);

    logic [CNT_W-1:0] r_phase;
    logic             w_terminal;

    // The period is clamped above PULSE_W by the caller, so period-1 never
    // underflows and phase+1 never overflows CNT_W bits.
    assign w_terminal = (r_phase == (i_period - CNT_W'(1)));

    // Phase register: load wins over counting, wrap at the terminal phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (i_load) begin
            r_phase <= '0;
        end else if (i_enable) begin
            r_phase <= w_terminal ? '0 : (r_phase + CNT_W'(1));
        end
    end

    assign o_terminal = w_terminal;
    assign o_inWindow = (r_phase < PULSE_W);
    assign o_fallNext = (r_phase == (PULSE_W - CNT_W'(1)));

endmodule

// File: rtl/step_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// step_pulse_scheduler
// Accepts a move command (period, step count, direction) and emits that many
// step pulses, each PULSE_W cycles high, one per effective period. Signals a
// one-cycle done pulse at the end of the move or after an abort.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   cmd_valid   command offered
//   cmd_ready   scheduler idle and able to accept a command
//   cmd_period  cycles per step (clamped up to PULSE_W+1)
//   cmd_steps   number of step pulses (0 gives an immediate done)
//   cmd_dir     direction for the move
//   abort       terminate the current move
//   step        step pulse to the motor driver
//   dir         direction latched at the last accepted command
//   busy        move in progress
//   done        one-cycle end-of-move pulse
//   steps_left  remaining step count
// -----------------------------------------------------------------------------
module step_pulse_scheduler
    import step_pulse_scheduler_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter int               STEPS_W = DEF_STEPS_W,
    parameter logic [CNT_W-1:0] PULSE_W = CNT_W'(50)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_period,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               cmd_dir,
    input  logic               abort,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic [STEPS_W-1:0] steps_left
);

    state_t             r_state;
    logic               r_step;
    logic               r_dir;
    logic               r_busy;
    logic               r_done;
    logic [STEPS_W-1:0] r_stepsLeft;
    logic [CNT_W-1:0]   r_period;

    logic               w_accept;
    logic [CNT_W-1:0]   w_clampPeriod;
    logic               w_enable;
    logic               w_terminal;
    logic               w_inWindow;
    logic               w_fallNext;

    // Ready is held low during reset so nothing can be taken while the state
    // is being cleared; abort in IDLE simply blocks acceptance.
    assign cmd_ready = (r_state == IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready && !abort;

    // The period must leave at least one low cycle after the pulse window
    assign w_clampPeriod = (cmd_period > PULSE_W) ? cmd_period : (PULSE_W + CNT_W'(1));

    // Phase only advances in RUN; an abort freezes it for the exit cycle
    assign w_enable = (r_state == RUN) && !abort;

    step_phase_counter #(
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) u_phase (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_accept),
        .i_enable   (w_enable),
        .i_period   (r_period),
        .o_terminal (w_terminal),
        .o_inWindow (w_inWindow),
        .o_fallNext (w_fallNext)
    );

    // Scheduler FSM with registered outputs. r_step holds the value of step
    // for the next phase, so the first pulse starts the cycle after accept.
    // A pulse is counted only on its natural fall, so an aborted pulse
    // leaves steps_left untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stepsLeft <= '0;
            r_period    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_dir       <= cmd_dir;
                        r_stepsLeft <= cmd_steps;
                        r_period    <= w_clampPeriod;
                        if (cmd_steps == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_step  <= 1'b0;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_step  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort || (w_terminal && (r_stepsLeft == '0))) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_step  <= 1'b0;
                    end else begin
                        if (w_terminal) begin
                            r_step <= 1'b1;
                        end else begin
                            r_step <= w_inWindow && !w_fallNext;
                        end
                        if (w_fallNext) begin
                            r_stepsLeft <= r_stepsLeft - STEPS_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_step  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_step  <= 1'b0;
                end
            endcase
        end
    end

    // Abort must silence the driver in the same cycle, ahead of the register
    assign step       = r_step && !abort;
    assign dir        = r_dir;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_left = r_stepsLeft;

endmodule

// File: tb/tb_step_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_step_pulse_scheduler
// Directed bench for step_pulse_scheduler with PULSE_W=2. Table vectors give
// per-cycle step patterns and done timing; hand sequences cover held
// cmd_valid, abort in IDLE and reset mid-move.
// -----------------------------------------------------------------------------
module tb_step_pulse_scheduler;

    localparam int               CNT_W   = 28;
    localparam int               STEPS_W = 16;
    localparam logic [CNT_W-1:0] PULSE_W = 28'd2;

    logic               clock     = 1'b0;
    logic               reset     = 1'b1;
    logic               cmdValid  = 1'b0;
    logic               cmdDir    = 1'b0;
    logic               abort     = 1'b0;
    logic [CNT_W-1:0]   cmdPeriod = '0;
    logic [STEPS_W-1:0] cmdSteps  = '0;

    logic               cmdReady;
    logic               step;
    logic               dir;
    logic               busy;
    logic               done;
    logic [STEPS_W-1:0] stepsLeft;

    int checkCount = 0;
    int passCount  = 0;

    // One move: stepMask bit k is the expected step level in cycle N+k after
    // the accepting edge N; abortCycle 0 means no abort.
    typedef struct {
        logic [CNT_W-1:0]   period;
        logic [STEPS_W-1:0] steps;
        logic               dirIn;
        int                 abortCycle;
        logic [31:0]        stepMask;
        int                 doneCycle;
        logic [STEPS_W-1:0] finalSteps;
    } vector_t;

    vector_t vectors [6];

    step_pulse_scheduler #(
        .CNT_W   (CNT_W),
        .STEPS_W (STEPS_W),
        .PULSE_W (PULSE_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_period (cmdPeriod),
        .cmd_steps  (cmdSteps),
        .cmd_dir    (cmdDir),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .steps_left (stepsLeft)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // Hard stop in case a sequence never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actualV,
                               input logic [31:0] expectedV);
        checkCount++;
        if (actualV === expectedV) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actualV, expectedV);
        end
    endtask

    // Offer a command for exactly one edge; returns #1 after the accepting edge
    task automatic applyStimulus(input logic [CNT_W-1:0] period,
                                 input logic [STEPS_W-1:0] steps, input logic dirIn);
        cmdPeriod = period;
        cmdSteps  = steps;
        cmdDir    = dirIn;
        cmdValid  = 1'b1;
        @(posedge clock);
        #1;
        cmdValid  = 1'b0;
    endtask

    // Run one table vector, checking every cycle up to one past done
    task automatic runVector(input int idx, input vector_t v);
        logic [STEPS_W-1:0] expLeft;
        expLeft = v.steps;
        applyStimulus(v.period, v.steps, v.dirIn);
        for (int k = 1; k <= v.doneCycle + 1; k++) begin
            abort = (k == v.abortCycle);
            if (k >= 2 && v.stepMask[k-1] && !v.stepMask[k] && k != v.abortCycle)
                expLeft = expLeft - STEPS_W'(1);
            @(negedge clock);
            checkOutput($sformatf("v%0d step c%0d", idx, k), 32'(step), 32'(v.stepMask[k]));
            checkOutput($sformatf("v%0d done c%0d", idx, k), 32'(done), 32'(k == v.doneCycle));
            checkOutput($sformatf("v%0d ready c%0d", idx, k), 32'(cmdReady),
                        32'(k == v.doneCycle + 1));
            if (k == 1)
                checkOutput($sformatf("v%0d dir", idx), 32'(dir), 32'(v.dirIn));
            if (k <= v.doneCycle) begin
                checkOutput($sformatf("v%0d busy c%0d", idx, k), 32'(busy),
                            32'(k < v.doneCycle));
                checkOutput($sformatf("v%0d steps_left c%0d", idx, k), 32'(stepsLeft),
                            32'(expLeft));
            end
            if (k == v.doneCycle)
                checkOutput($sformatf("v%0d final steps_left", idx), 32'(stepsLeft),
                            32'(v.finalSteps));
            @(posedge clock);
            #1;
        end
        abort = 1'b0;
    endtask

    // Main sequence
    initial begin
        int  waited;
        logic doneSeen;

        // period, steps, dir, abortCycle, stepMask, doneCycle, finalSteps
        vectors[0] = '{28'd5, 16'd3, 1'b1, 0, 32'h0000_18C6, 16, 16'd0};
        vectors[1] = '{28'd5, 16'd0, 1'b0, 0, 32'h0000_0000,  1, 16'd0};
        vectors[2] = '{28'd1, 16'd2, 1'b0, 0, 32'h0000_0036,  7, 16'd0};
        vectors[3] = '{28'd5, 16'd3, 1'b1, 7, 32'h0000_0046,  8, 16'd2};
        vectors[4] = '{28'd3, 16'd1, 1'b1, 0, 32'h0000_0006,  4, 16'd0};
        vectors[5] = '{28'd4, 16'd2, 1'b0, 0, 32'h0000_0066,  9, 16'd0};

        // Reset values while reset is held
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset step", 32'(step), 32'd0);
        checkOutput("reset dir", 32'(dir), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset steps_left", 32'(stepsLeft), 32'd0);
        checkOutput("reset ready", 32'(cmdReady), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("ready after release", 32'(cmdReady), 32'd1);
        @(posedge clock);
        #1;

        for (int i = 0; i < 6; i++) begin
            runVector(i, vectors[i]);
        end

        // Held cmd_valid during a move: no re-latch, accepted after done
        cmdPeriod = 28'd5;
        cmdSteps  = 16'd1;
        cmdDir    = 1'b1;
        cmdValid  = 1'b1;
        @(posedge clock);
        #1;
        cmdPeriod = 28'd3;
        cmdDir    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k <= 5) begin
                checkOutput($sformatf("held busy c%0d", k), 32'(busy), 32'd1);
                checkOutput($sformatf("held ready c%0d", k), 32'(cmdReady), 32'd0);
            end
            if (k <= 7)
                checkOutput($sformatf("held dir c%0d", k), 32'(dir), 32'd1);
            if (k == 6)
                checkOutput("held done", 32'(done), 32'd1);
            if (k == 7)
                checkOutput("held ready after done", 32'(cmdReady), 32'd1);
            if (k == 8) begin
                checkOutput("held relatch busy", 32'(busy), 32'd1);
                checkOutput("held relatch dir", 32'(dir), 32'd0);
                checkOutput("held relatch step", 32'(step), 32'd1);
                checkOutput("held relatch steps_left", 32'(stepsLeft), 32'd1);
            end
            @(posedge clock);
            #1;
        end
        cmdValid = 1'b0;
        doneSeen = 1'b0;
        waited   = 0;
        while (!doneSeen && waited < 20) begin
            @(negedge clock);
            waited++;
            if (done) doneSeen = 1'b1;
        end
        checkOutput("held second done seen", 32'(doneSeen), 32'd1);
        checkOutput("held second done latency", 32'(waited), 32'd3);
        @(posedge clock);
        #1;

        // Abort in IDLE only blocks acceptance
        cmdPeriod = 28'd5;
        cmdSteps  = 16'd2;
        cmdDir    = 1'b1;
        cmdValid  = 1'b1;
        abort     = 1'b1;
        @(posedge clock);
        #1;
        cmdValid  = 1'b0;
        abort     = 1'b0;
        @(negedge clock);
        checkOutput("idle abort busy", 32'(busy), 32'd0);
        checkOutput("idle abort ready", 32'(cmdReady), 32'd1);
        checkOutput("idle abort dir", 32'(dir), 32'd0);
        checkOutput("idle abort steps_left", 32'(stepsLeft), 32'd0);
        @(posedge clock);
        #1;

        // Reset pulsed in cycle N+6 of a 3-step move
        applyStimulus(28'd5, 16'd3, 1'b1);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        #1;
        checkOutput("rst pre step", 32'(step), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst step", 32'(step), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst dir", 32'(dir), 32'd0);
        checkOutput("rst steps_left", 32'(stepsLeft), 32'd0);
        checkOutput("rst ready", 32'(cmdReady), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("rst held done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst release ready", 32'(cmdReady), 32'd1);
        checkOutput("rst release done", 32'(done), 32'd0);
        applyStimulus(28'd5, 16'd0, 1'b0);
        @(negedge clock);
        checkOutput("post rst done", 32'(done), 32'd1);
        checkOutput("post rst busy", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("post rst ready", 32'(cmdReady), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
